// File: rtl/gray_scan_display.sv
// gray_scan_display: prescaled up/down counter with runtime Gray/binary
// output coding and parallel load, shown one digit at a time on a shared
// seven-segment bus ('0' / '1' per bit, MSB on digit 0).
// Optional build macro GRAY_SCAN_DP_EN: decimal point marks the most
// significant output bit that toggled on the last count step.
module gray_scan_display #(
  parameter int WIDTH    = 6,
  parameter int PRESCALE = 4,
  parameter int SCAN_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_mode,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_cnt,
  output logic             o_step,
  output logic [WIDTH-1:0] o_digit_sel,
  output logic [7:0]       o_seg
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (WIDTH > 1)    ? $clog2(WIDTH)    : 1;

  localparam logic [PW-1:0] PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [SW-1:0] DWELL_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] D_LAST     = DW'(WIDTH - 1);

  localparam logic [6:0] SEG_ZERO = 7'h3F;
  localparam logic [6:0] SEG_ONE  = 7'h06;

  logic [WIDTH-1:0] r_bin;
  logic [PW-1:0]    r_pre;
  logic [SW-1:0]    r_dwell;
  logic [DW-1:0]    r_d;

  logic             w_tick;
  logic [PW-1:0]    w_pre_next;
  logic [WIDTH-1:0] w_bin_next;
  logic [WIDTH-1:0] w_cnt_next;
  logic             w_dwell_last;
  logic [SW-1:0]    w_dwell_next;
  logic [DW-1:0]    w_d_next;
  logic [WIDTH-1:0] w_cnt_rev;
  logic [6:0]       w_seg_lo;
  logic             w_dp;

  assign w_tick = i_en && (r_pre == PRE_LAST);

  // Prescaler and binary counter next state; load overrides counting.
  always_comb begin
    w_pre_next = r_pre;
    w_bin_next = r_bin;
    if (i_load) begin
      w_pre_next = '0;
      w_bin_next = i_load_val;
    end else if (i_en) begin
      if (w_tick) begin
        w_pre_next = '0;
        w_bin_next = i_up ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
      end else begin
        w_pre_next = r_pre + PW'(1);
      end
    end
  end

  assign w_cnt_next = i_mode ? w_bin_next : (w_bin_next ^ (w_bin_next >> 1));

  // Scan position next state: dwell on each digit, then advance and wrap.
  always_comb begin
    w_dwell_last = (r_dwell == DWELL_LAST);
    w_dwell_next = w_dwell_last ? '0 : (r_dwell + SW'(1));
    w_d_next     = r_d;
    if (w_dwell_last)
      w_d_next = (r_d == D_LAST) ? '0 : (r_d + DW'(1));
  end

  // Bit-reversed view so digit index d addresses cnt bit WIDTH-1-d.
  always_comb begin
    w_cnt_rev = '0;
    for (int i = 0; i < WIDTH; i++)
      w_cnt_rev[i] = w_cnt_next[WIDTH-1-i];
  end

  assign w_seg_lo = w_cnt_rev[w_d_next] ? SEG_ONE : SEG_ZERO;

`ifdef GRAY_SCAN_DP_EN
  logic [WIDTH-1:0] r_chg;
  logic             r_mode;
  logic [WIDTH-1:0] w_toggled;
  logic [WIDTH-1:0] w_top;
  logic [WIDTH-1:0] w_chg_next;
  logic [WIDTH-1:0] w_chg_rev;

  assign w_toggled = w_cnt_next ^ o_cnt;

  // Keep only the highest toggled bit (one-hot or zero).
  always_comb begin
    w_top = '0;
    for (int i = 0; i < WIDTH; i++)
      if (w_toggled[i]) w_top = WIDTH'(1) << i;
  end

  // Changed-digit marker: cleared by load or recoding, captured on a step.
  always_comb begin
    w_chg_next = r_chg;
    if (i_load || (i_mode != r_mode))
      w_chg_next = '0;
    else if (w_tick)
      w_chg_next = w_top;
  end

  // Reverse so the marker lines up with the digit index.
  always_comb begin
    w_chg_rev = '0;
    for (int i = 0; i < WIDTH; i++)
      w_chg_rev[i] = w_chg_next[WIDTH-1-i];
  end

  assign w_dp = w_chg_rev[w_d_next];

  // Marker and last-seen mode registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_chg  <= '0;
      r_mode <= i_mode;
    end else begin
      r_chg  <= w_chg_next;
      r_mode <= i_mode;
    end
  end
`else
  assign w_dp = 1'b0;
`endif

  // Counter state and coded outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bin  <= '0;
      r_pre  <= '0;
      o_cnt  <= '0;
      o_step <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_pre  <= w_pre_next;
      o_cnt  <= w_cnt_next;
      o_step <= w_tick & ~i_load;
    end
  end

  // Scan state; digit enable and segments both come from next-state d.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dwell     <= '0;
      r_d         <= '0;
      o_digit_sel <= WIDTH'(1);
      o_seg       <= {1'b0, SEG_ZERO};
    end else begin
      r_dwell     <= w_dwell_next;
      r_d         <= w_d_next;
      o_digit_sel <= WIDTH'(1) << w_d_next;
      o_seg       <= {w_dp, w_seg_lo};
    end
  end

endmodule

// File: doc/gray_scan_display.md
Name: gray_scan_display

Overview:
- Parametrised successor to the static Gray-counter LED bank.
- Prescaled up/down counter with runtime Gray/binary output mode and parallel load.
- Drives one shared 7-segment bus, time-multiplexed across WIDTH digits: one digit lit at a time, showing '0' or '1', MSB on digit 0.
- Sits between the board clock/switches and the multiplexed seven-segment header.

Parameters:
- WIDTH, 6: counter bits = digit count; legal 1..16.
- PRESCALE, 4: enabled clocks per count step; legal >= 1.
- SCAN_DIV, 2: clocks each digit stays selected; legal >= 1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  count enable; gates the prescaler.
- up  in  1  1 = increment, 0 = decrement.
- mode  in  1  0 = Gray output, 1 = plain binary output.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  binary value to load.
- cnt  out  WIDTH  registered counter output, coded per mode.
- step  out  1  one-cycle pulse, the cycle after each count step.
- digit_sel  out  WIDTH  one-hot active-high digit enable.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-high.

Behaviour:
- Reset (rst=1 at edge) sets bin=0, pre=0, cnt=0, step=0, scan index d=0, dwell=0, digit_sel=1, seg=8'h3F ('0'). A reset mid-operation aborts everything and gives exactly these values on the next cycle.
- Internal binary counter bin, WIDTH bits.
- Prescaler pre counts 0..PRESCALE-1 only while en=1. tick = en & (pre==PRESCALE-1). On tick, pre returns to 0. With en=0, pre holds.
- On tick: bin_next = up ? bin+1 : bin-1, modulo 2^WIDTH. Up from all-ones wraps to 0; down from 0 wraps to all-ones.
- Load priority: load=1 gives bin_next=load_val and pre=0, regardless of en or tick. No step pulse on load.
- cnt is registered every cycle as mode ? bin_next : bin_next ^ (bin_next>>1). It changes on the same edge as bin. A mode change alone re-codes cnt on the next edge.
- step is registered as tick & ~load. It is high for one cycle, aligned with the new cnt.
- PRESCALE=1 with en held high: a step every cycle.
- Scan logic runs independently of en and load:
  - dwell counts 0..SCAN_DIV-1.
  - At dwell==SCAN_DIV-1, d advances by 1 and wraps WIDTH-1 -> 0.
  - Both digit_sel and seg are registered from next-state d, so they are always aligned.
  - digit_sel = 1<<d.
  - seg[6:0] = 7'h3F if cnt_next[WIDTH-1-d]==0, else 7'h06.
  - seg[7] = 0 (see Optional Feature).
- WIDTH=1: d stays 0, digit_sel stays 1.
- Outputs never glitch between edges. Every output is a flop.

Optional Feature:
- Macro: GRAY_SCAN_DP_EN.
- When defined:
  - A WIDTH-bit register chg holds the most significant cnt bit that toggled on the last step.
  - chg is one-hot or zero. In Gray mode exactly one bit toggles; in binary mode the highest toggled bit is used.
  - chg updates only on tick without load.
  - chg clears to 0 on reset, load, or a mode change.
  - seg[7] = chg[WIDTH-1-d]: the decimal point marks the changed digit while that digit is selected.
- When undefined: no chg register, and seg[7] is constant 0.

Test Plan:
- Bench parameters: WIDTH=3, PRESCALE=2, SCAN_DIV=1 unless noted.
1. Reset, then en=1, up=1, mode=0 for 16 cycles -> cnt sequence 000,001,011,010,110,111,101,100,000, changing every 2 cycles, with step pulsed each change.
2. mode=1, up=0 from reset -> first step gives cnt=111 (wrap), then 110, 101. Toggling en low for 5 cycles freezes cnt and emits no step.
3. load=1 with load_val=101 on the same cycle as a tick, mode=1 -> next cycle cnt=101 and step=0. The next tick occurs exactly 2 enabled cycles later.
4. Scan check with cnt=110 frozen (en=0) -> digit_sel cycles 001,010,100,001 each cycle. seg follows: 3'h06 on digit 0, 06 on digit 1, 3F on digit 2 (i.e. 8'h06, 8'h06, 8'h3F). With SCAN_DIV=3, each digit holds for 3 cycles.
5. Assert rst mid-count (cnt=011, d=2) -> next cycle cnt=000, step=0, digit_sel=001, seg=8'h3F. Counting resumes with a full PRESCALE wait.
6. With GRAY_SCAN_DP_EN, Gray mode, step 010->110 -> dp=1 only while digit 0 is selected. A following load clears dp on all digits.
